// File: rtl/add_accum_unit.sv
// Add/subtract/accumulate unit with a one-deep valid/ready output register.
// The accumulator clamps or wraps on overflow and a sticky flag records that it happened.
module add_accum_unit #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 carry,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] acc_count
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
  localparam logic [ACC_WIDTH-1:0] ACC_ONES = {ACC_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] result_r;
  logic                 carry_r;
  logic                 ovf_r;
  logic [CNT_WIDTH-1:0] acc_count_r;
  logic                 out_valid_r;

  logic                 accept_s;
  logic [WIDTH:0]       add_sum_s;
  logic [WIDTH-1:0]     sub_diff_s;
  logic [SUM_W-1:0]     acc_sum_s;
  logic [ACC_WIDTH-1:0] nxt_result_s;
  logic [ACC_WIDTH-1:0] nxt_acc_s;
  logic                 nxt_carry_s;
  logic                 nxt_ovf_s;
  logic [CNT_WIDTH-1:0] nxt_cnt_s;

  // A held result blocks new work unless the consumer drains it this same cycle.
  assign in_ready   = ~out_valid_r | out_ready;
  assign accept_s   = in_valid & in_ready;
  assign add_sum_s  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_diff_s = op_a - op_b;
  assign acc_sum_s  = {1'b0, acc_r} + SUM_W'(op_a) + SUM_W'(op_b);

  assign result    = result_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;
  assign acc_count = acc_count_r;
  assign out_valid = out_valid_r;

  // Next-state values for one accepted transaction, selected by mode.
  always_comb begin
    nxt_result_s = result_r;
    nxt_carry_s  = carry_r;
    nxt_acc_s    = acc_r;
    nxt_ovf_s    = ovf_r;
    nxt_cnt_s    = acc_count_r;
    case (mode)
      2'b00: begin
        nxt_result_s = ACC_WIDTH'(add_sum_s);
        nxt_carry_s  = add_sum_s[WIDTH];
      end
      2'b01: begin
        nxt_result_s = ACC_WIDTH'(sub_diff_s);
        nxt_carry_s  = (op_a < op_b);
      end
      2'b10: begin
        if (acc_sum_s[ACC_WIDTH]) begin
          nxt_ovf_s = 1'b1;
          if (SATURATE != 0) begin
            nxt_acc_s = ACC_ONES;
          end else begin
            nxt_acc_s = acc_sum_s[ACC_WIDTH-1:0];
          end
        end else begin
          nxt_acc_s = acc_sum_s[ACC_WIDTH-1:0];
        end
        if (acc_count_r != CNT_ONES) begin
          nxt_cnt_s = acc_count_r + CNT_ONE;
        end else begin
          nxt_cnt_s = acc_count_r;
        end
        nxt_result_s = nxt_acc_s;
        nxt_carry_s  = 1'b0;
      end
      2'b11: begin
        nxt_result_s = ACC_ZERO;
        nxt_carry_s  = 1'b0;
        nxt_acc_s    = ACC_ZERO;
        nxt_ovf_s    = 1'b0;
        nxt_cnt_s    = CNT_ZERO;
      end
      default: begin
        nxt_result_s = result_r;
        nxt_carry_s  = carry_r;
      end
    endcase
  end

  // State and output registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= ACC_ZERO;
      result_r    <= ACC_ZERO;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      acc_count_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      acc_r       <= nxt_acc_s;
      result_r    <= nxt_result_s;
      carry_r     <= nxt_carry_s;
      ovf_r       <= nxt_ovf_s;
      acc_count_r <= nxt_cnt_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_add_accum_unit.sv
// Bench for add_accum_unit: a clamping and a wrapping instance share stimulus and are
// compared against an arithmetic reference model plus directed known-answer cases.
module tb_add_accum_unit;

  localparam int W = 4, AW = 8, CW = 4;
  localparam int OP_MOD = 1 << W, ACC_MOD = 1 << AW, ACC_MAX = ACC_MOD - 1, CNT_MAX = (1 << CW) - 1;

  logic clk, reset, in_valid, out_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0] mode;
  logic s_in_ready, s_out_valid, s_carry, s_ovf;
  logic w_in_ready, w_out_valid, w_carry, w_ovf;
  logic [AW-1:0] s_result, w_result;
  logic [CW-1:0] s_count, w_count;

  int errors = 0, checks = 0;
  int m_acc[2], m_ovf[2], m_cnt[2], m_res[2], m_carry[2];
  bit m_valid;
  bit obs_ready_s, obs_ready_w, exp_ready;

  add_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1), .CNT_WIDTH(CW)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .op_a(op_a), .op_b(op_b),
    .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result), .carry(s_carry),
    .ovf(s_ovf), .acc_count(s_count));

  add_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(0), .CNT_WIDTH(CW)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .op_a(op_a), .op_b(op_b),
    .mode(mode), .out_valid(w_out_valid), .out_ready(out_ready), .result(w_result), .carry(w_carry),
    .ovf(w_ovf), .acc_count(w_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one accepted transaction; index 0 clamps, index 1 wraps.
  task automatic model_txn(input logic [1:0] m, input int a, input int b);
    for (int k = 0; k < 2; k++) begin
      int s;
      case (m)
        2'b00: begin s = a + b; m_res[k] = s; m_carry[k] = (s >= OP_MOD); end
        2'b01: begin m_res[k] = (a - b + OP_MOD) % OP_MOD; m_carry[k] = (a < b); end
        2'b10: begin
          s = m_acc[k] + a + b;
          if (s > ACC_MAX) begin m_ovf[k] = 1; m_acc[k] = (k == 0) ? ACC_MAX : s - ACC_MOD; end
          else m_acc[k] = s;
          if (m_cnt[k] < CNT_MAX) m_cnt[k] = m_cnt[k] + 1;
          m_res[k] = m_acc[k]; m_carry[k] = 0;
        end
        default: begin m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_res[k] = 0; m_carry[k] = 0; end
      endcase
    end
    m_valid = 1;
  endtask

  // Drive one cycle, sample in_ready before the edge, update the model, settle after the edge.
  task automatic step(input bit v, input bit rdy, input logic [1:0] m, input int a, input int b, input bit rst);
    in_valid = v; out_ready = rdy; mode = m; op_a = a[W-1:0]; op_b = b[W-1:0]; reset = rst;
    #1;
    obs_ready_s = s_in_ready; obs_ready_w = w_in_ready;
    exp_ready = !m_valid || rdy;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_res[k] = 0; m_carry[k] = 0; end
      m_valid = 0;
    end else if (v && exp_ready) model_txn(m, a, b);
    else if (rdy) m_valid = 0;
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    step(1'b1, 1'b1, 2'b10, 5, 5, 1'b1);
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_result !== 8'h00) begin errors++; $display("FAIL rst_result got=%h exp=00", s_result); end
    checks++; if (s_carry !== 1'b0 || s_ovf !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", s_carry, s_ovf); end
    checks++; if (s_count !== 4'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", s_count); end
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    checks++; if (obs_ready_s !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", obs_ready_s); end
  endtask

  task automatic test_add_sub;
    step(1'b1, 1'b1, 2'b00, 7, 9, 1'b0);
    checks++; if (s_result !== 8'h10 || s_carry !== 1'b1) begin errors++; $display("FAIL add_7_9 got=%h/%b exp=10/1", s_result, s_carry); end
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", s_out_valid); end
    step(1'b1, 1'b1, 2'b01, 3, 5, 1'b0);
    checks++; if (s_result !== 8'h0E || s_carry !== 1'b1) begin errors++; $display("FAIL sub_3_5 got=%h/%b exp=0e/1", s_result, s_carry); end
    step(1'b1, 1'b1, 2'b01, 9, 4, 1'b0);
    checks++; if (s_result !== 8'h05 || s_carry !== 1'b0) begin errors++; $display("FAIL sub_9_4 got=%h/%b exp=05/0", s_result, s_carry); end
  endtask

  task automatic test_accumulate;
    step(1'b1, 1'b1, 2'b11, 0, 0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 2'b10, 15, 15, 1'b0);
      if (i == 8) begin
        checks++; if (s_result !== 8'hF0 || s_ovf !== 1'b0) begin errors++; $display("FAIL acc8_sat got=%h/%b exp=f0/0", s_result, s_ovf); end
        checks++; if (w_result !== 8'hF0 || w_ovf !== 1'b0) begin errors++; $display("FAIL acc8_wrap got=%h/%b exp=f0/0", w_result, w_ovf); end
      end
      if (i == 9) begin
        checks++; if (s_result !== 8'hFF || s_ovf !== 1'b1) begin errors++; $display("FAIL acc9_sat got=%h/%b exp=ff/1", s_result, s_ovf); end
        checks++; if (s_count !== 4'd9) begin errors++; $display("FAIL acc9_count got=%0d exp=9", s_count); end
        checks++; if (w_result !== 8'h0E || w_ovf !== 1'b1) begin errors++; $display("FAIL acc9_wrap got=%h/%b exp=0e/1", w_result, w_ovf); end
      end
      if (i == 10) begin
        checks++; if (s_result !== 8'hFF || s_ovf !== 1'b1 || s_carry !== 1'b0) begin errors++; $display("FAIL acc10_sat got=%h/%b/%b exp=ff/1/0", s_result, s_ovf, s_carry); end
      end
    end
  endtask

  task automatic test_clear;
    step(1'b1, 1'b1, 2'b11, 3, 3, 1'b0);
    checks++; if (s_result !== 8'h00 || s_ovf !== 1'b0 || s_count !== 4'h0) begin errors++; $display("FAIL clr got=%h/%b/%h exp=00/0/0", s_result, s_ovf, s_count); end
    checks++; if (w_ovf !== 1'b0 || w_count !== 4'h0) begin errors++; $display("FAIL clr_wrap got=%b/%h exp=0/0", w_ovf, w_count); end
    step(1'b1, 1'b1, 2'b10, 1, 1, 1'b0);
    checks++; if (s_result !== 8'h02 || w_result !== 8'h02 || s_count !== 4'h1) begin errors++; $display("FAIL clr_acc got=%h/%h/%h exp=02/02/1", s_result, w_result, s_count); end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b1, 2'b00, 1, 2, 1'b0);
    checks++; if (s_result !== 8'h03) begin errors++; $display("FAIL bp_first got=%h exp=03", s_result); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b00, 4, 4, 1'b0);
      checks++; if (obs_ready_s !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, obs_ready_s); end
      checks++; if (s_result !== 8'h03 || s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=03/1", i, s_result, s_out_valid); end
    end
    step(1'b1, 1'b1, 2'b00, 4, 4, 1'b0);
    checks++; if (obs_ready_s !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", obs_ready_s); end
    checks++; if (s_result !== 8'h08 || s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_release got=%h/%b exp=08/1", s_result, s_out_valid); end
    step(1'b0, 1'b1, 2'b01, 0, 0, 1'b0);
    checks++; if (s_out_valid !== 1'b0 || s_result !== 8'h08) begin errors++; $display("FAIL drain got=%b/%h exp=0/08", s_out_valid, s_result); end
  endtask

  task automatic test_reset_pending;
    step(1'b1, 1'b0, 2'b10, 2, 3, 1'b0);
    checks++; if (s_out_valid !== 1'b1 || s_result !== 8'h07) begin errors++; $display("FAIL pend_setup got=%b/%h exp=1/07", s_out_valid, s_result); end
    step(1'b1, 1'b0, 2'b00, 1, 1, 1'b1);
    checks++; if (s_out_valid !== 1'b0 || s_result !== 8'h00) begin errors++; $display("FAIL pend_reset got=%b/%h exp=0/00", s_out_valid, s_result); end
    step(1'b1, 1'b1, 2'b10, 1, 0, 1'b0);
    checks++; if (obs_ready_s !== 1'b1) begin errors++; $display("FAIL pend_ready got=%b exp=1", obs_ready_s); end
    checks++; if (s_result !== 8'h01 || s_count !== 4'h1) begin errors++; $display("FAIL pend_acc got=%h/%h exp=01/1", s_result, s_count); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] m;
      r = $urandom_range(0, 7);
      m = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, m, $urandom_range(0, OP_MOD - 1),
           $urandom_range(0, OP_MOD - 1), $urandom_range(0, 63) == 0);
      checks++; if (obs_ready_s !== exp_ready || obs_ready_w !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b", i, obs_ready_s, obs_ready_w, exp_ready); end
      checks++; if (s_out_valid !== m_valid || w_out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b", i, s_out_valid, w_out_valid, m_valid); end
      checks++; if (s_result !== AW'(m_res[0]) || w_result !== AW'(m_res[1])) begin errors++; $display("FAIL rnd_result cyc=%0d got=%h/%h exp=%h/%h", i, s_result, w_result, AW'(m_res[0]), AW'(m_res[1])); end
      checks++; if (s_carry !== m_carry[0][0] || w_carry !== m_carry[1][0]) begin errors++; $display("FAIL rnd_carry cyc=%0d got=%b%b exp=%0d%0d", i, s_carry, w_carry, m_carry[0], m_carry[1]); end
      checks++; if (s_ovf !== m_ovf[0][0] || w_ovf !== m_ovf[1][0]) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b%b exp=%0d%0d", i, s_ovf, w_ovf, m_ovf[0], m_ovf[1]); end
      checks++; if (s_count !== CW'(m_cnt[0]) || w_count !== CW'(m_cnt[1])) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, s_count, w_count, m_cnt[0], m_cnt[1]); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00; op_a = 4'h0; op_b = 4'h0;
    m_valid = 0;
    test_reset();
    test_add_sub();
    test_accumulate();
    test_clear();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_accum_unit.md
ADD_ACCUM_UNIT -- requirements
Module: add_accum_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 Parameter ACC_WIDTH, default 8: accumulator/result width, legal range WIDTH+1..32.
REQ-003 Parameter SATURATE, default 1: 1 = accumulator clamps on overflow, 0 = accumulator wraps.
REQ-004 Parameter CNT_WIDTH, default 4: width of the accumulate-operation counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand/mode presented.
REQ-008 in_ready  output  1  unit can accept a transaction this cycle.
REQ-009 op_a, op_b  input  WIDTH each  unsigned operands.
REQ-010 mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-011 out_valid  output  1  result holds a completed transaction.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  ACC_WIDTH  registered result.
REQ-014 carry  output  1  carry (ADD) or borrow (SUB) of the last transaction.
REQ-015 ovf  output  1  sticky accumulator-overflow flag.
REQ-016 acc_count  output  CNT_WIDTH  number of ACC transactions since last CLR/reset.

Function
REQ-017 Accept = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-018 Latency: transaction accepted at edge N SHALL appear on result/carry with out_valid=1 after edge N.
REQ-019 out_valid && !out_ready: result, carry, out_valid SHALL hold unchanged; no operand accepted.
REQ-020 out_ready && accept same cycle: new result SHALL replace old; out_valid stays 1.
REQ-021 out_ready && !accept: out_valid SHALL fall to 0 at the next edge; result/carry hold last value.
REQ-022 ADD: result = zero-extended (op_a + op_b) at WIDTH+1 bits; carry = bit WIDTH of sum; accumulator unchanged.
REQ-023 SUB: result = zero-extended (op_a - op_b) mod 2^WIDTH; carry = 1 iff op_a < op_b; accumulator unchanged.
REQ-024 ACC: sum = acc + op_a + op_b at ACC_WIDTH+1 bits; if bit ACC_WIDTH set, ovf SHALL set and acc SHALL become all-ones (SATURATE=1) or sum mod 2^ACC_WIDTH (SATURATE=0); result = new acc; carry = 0.
REQ-025 ACC: acc_count SHALL increment by 1, saturating at 2^CNT_WIDTH-1.
REQ-026 CLR: acc, ovf, acc_count SHALL become 0; result = 0; carry = 0; out_valid set as for any transaction.
REQ-027 Once saturated (SATURATE=1), further ACC SHALL keep acc all-ones and ovf 1 until CLR.
REQ-028 ovf SHALL only be cleared by CLR or reset; ADD/SUB SHALL not affect ovf or acc_count.
REQ-029 Inputs not accepted (in_valid=0 or in_ready=0) SHALL have no effect on any state.

Reset
REQ-030 reset=1 at an edge SHALL force acc=0, result=0, carry=0, ovf=0, acc_count=0, out_valid=0, taking priority over any accept or out_ready that cycle.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts; a pending held result SHALL be discarded by reset.

Verification (WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=4)
REQ-032 ADD 7+9, out_ready=1 -> one edge later result=0x10, carry=1, out_valid=1.
REQ-033 SUB 3-5 -> result=0x0E, carry=1; SUB 9-4 -> result=0x05, carry=0.
REQ-034 SATURATE=1: 9 back-to-back ACC 15+15 -> after 8th result=0xF0 (240), ovf=0; after 9th result=0xFF, ovf=1, acc_count=9; SATURATE=0 same stimulus -> 9th result=0x0E, ovf=1.
REQ-035 Backpressure: ADD 1+2 with out_ready=0 for 5 cycles while in_valid=1 with ADD 4+4 -> result=0x03 held, in_ready=0; out_ready=1 -> next edge result=0x08.
REQ-036 CLR after REQ-034 -> result=0x00, ovf=0, acc_count=0; following ACC 1+1 -> result=0x02.
REQ-037 Reset asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, result=0, in_ready=1.
